// File: rtl/counter_bank.sv
// counter_bank: bank of independent up/down counters with sticky overflow flags
// and a sequential clear-all sweep; all state updates on the falling clock edge.
module counter_bank #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter int SATURATE = 0,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic [1:0]        op,
  input  logic              en,
  input  logic [WIDTH-1:0]  immediate,
  input  logic              clr_all,
  output logic [WIDTH-1:0]  data,
  output logic              ovf,
  output logic              busy
);
  typedef enum logic {IDLE, SWEEP} state_t;
  localparam logic [ADDR_W-1:0] LAST = (ADDR_W)'(DEPTH - 1);
  state_t state, state_n;
  logic [WIDTH-1:0] cnt [DEPTH];
  logic [DEPTH-1:0] flag;
  logic [ADDR_W-1:0] idx, idx_n;
  logic valid, upd_flag;
  logic [WIDTH-1:0] upd;
  logic [WIDTH:0] sum, diff;
  assign valid = {1'b0, addr} < (ADDR_W + 1)'(DEPTH);
  assign data = valid ? cnt[addr] : '0;
  assign ovf = valid ? flag[addr] : 1'b0;
  assign busy = state == SWEEP;
  // the extra top bit of sum/diff is the carry/borrow that sets the sticky flag
  always_comb begin
    sum = {1'b0, data} + {1'b0, immediate};
    diff = {1'b0, data} - {1'b0, immediate};
    upd = op == 2'b00 ? ((SATURATE != 0 && sum[WIDTH]) ? {WIDTH{1'b1}} : sum[WIDTH-1:0]) :
          op == 2'b01 ? ((SATURATE != 0 && diff[WIDTH]) ? {WIDTH{1'b0}} : diff[WIDTH-1:0]) :
          op == 2'b10 ? immediate : '0;
    upd_flag = op == 2'b00 ? (ovf | sum[WIDTH]) :
               op == 2'b01 ? (ovf | diff[WIDTH]) : 1'b0;
  end
  always_comb begin
    state_n = state;
    idx_n = idx;
    if (state == IDLE) begin
      if (clr_all) begin
        state_n = SWEEP;
        idx_n = '0;
      end
    end else begin
      idx_n = idx + 1'b1;
      if (idx == LAST) begin
        state_n = IDLE;
        idx_n = '0;
      end
    end
  end
  // clr_all in IDLE wins over a same-edge en op, which is dropped
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      flag <= '0;
      for (int i = 0; i < DEPTH; i++) cnt[i] <= '0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      if (busy) begin
        cnt[idx] <= '0;
        flag[idx] <= 1'b0;
      end else if (en && valid && !clr_all) begin
        cnt[addr] <= upd;
        flag[addr] <= upd_flag;
      end
    end
  end
endmodule
